// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: command op encoding and a
// width helper used to size address and requester-id fields.
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  // Index width that never collapses to zero bits, even for a single entry.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell of the shared bank; {j,k} uses the command op
// encoding directly (hold, reset, set, toggle).
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        OP_RST:  q <= 1'b0;
        OP_SET:  q <= 1'b1;
        OP_TOG:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one JK command per cycle to a shared bank of
// JK cells, with a registered acknowledgement carrying the updated bit.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int AW    = clog2_min1(NBITS),
  parameter int IDW   = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [AW*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [NBITS-1:0]     q,
  output logic                 ack_valid,
  output logic [IDW-1:0]       ack_id,
  output logic                 ack_q,
  output logic                 ack_err
);

  logic [IDW-1:0]   rr_ptr;
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [1:0]       win_op;
  logic [AW-1:0]    win_addr;
  logic             xfer;
  logic             addr_ok;
  logic             cur_bit;
  logic             new_bit;
  logic [NBITS-1:0] cell_j;
  logic [NBITS-1:0] cell_k;

  // Winner is the valid requester with the smallest distance past rr_ptr.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int best_d;
    int d;
    win_found = 1'b0;
    win_id    = '0;
    win_op    = OP_HOLD;
    win_addr  = '0;
    best_d    = NREQ;
    d         = 0;
    for (int r = 0; r < NREQ; r++) begin
      d = r - int'(rr_ptr);
      if (d < 0) d = d + NREQ;
      if (req_valid[r] && d < best_d) begin
        best_d    = d;
        win_found = 1'b1;
        win_id    = IDW'(r);
        win_op    = req_op[2*r +: 2];
        win_addr  = req_addr[AW*r +: AW];
      end
    end
  end

  // A grant is withheld while the bank is being cleared or held in reset.
  assign xfer = win_found & ~clr & rst_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win_id] = 1'b1;
  end

  // Per-cell J/K decode; clr drives every cell to its reset op.
  always_comb begin
    logic hit;
    cell_j  = '0;
    cell_k  = '0;
    addr_ok = 1'b0;
    cur_bit = 1'b0;
    hit     = 1'b0;
    for (int b = 0; b < NBITS; b++) begin
      hit = (win_addr == AW'(b));
      if (hit) begin
        addr_ok = 1'b1;
        cur_bit = q[b];
      end
      if (clr) begin
        cell_k[b] = 1'b1;
      end else if (xfer && hit) begin
        cell_j[b] = win_op[1];
        cell_k[b] = win_op[0];
      end
    end
  end

  // Value the addressed cell will hold after this edge, reported in the ack.
  always_comb begin
    case (win_op)
      OP_RST:  new_bit = 1'b0;
      OP_SET:  new_bit = 1'b1;
      OP_TOG:  new_bit = ~cur_bit;
      default: new_bit = cur_bit;
    endcase
  end

  for (genvar b = 0; b < NBITS; b++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (cell_j[b]),
      .k     (cell_k[b]),
      .q     (q[b])
    );
  end

  // Ack payload holds its last value whenever no command transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      ack_valid <= 1'b0;
      ack_id    <= '0;
      ack_q     <= 1'b0;
      ack_err   <= 1'b0;
    end else if (xfer) begin
      rr_ptr    <= (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
      ack_valid <= 1'b1;
      ack_id    <= win_id;
      ack_q     <= addr_ok & new_bit;
      ack_err   <= ~addr_ok;
    end else begin
      ack_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter with NBITS=6 so that addresses 6
// and 7 exercise the out-of-range path; directed scenarios plus random traffic.
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int AW    = 3;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [2*NREQ-1:0]  req_op = '0;
  logic [AW*NREQ-1:0] req_addr = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NBITS-1:0]   q;
  logic               ack_valid;
  logic [IDW-1:0]     ack_id;
  logic               ack_q;
  logic               ack_err;

  int checks = 0;
  int errors = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .q         (q),
    .ack_valid (ack_valid),
    .ack_id    (ack_id),
    .ack_q     (ack_q),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] v, input logic [7:0] op,
                       input logic [11:0] a, input logic c);
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    clr       = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hf; req_op = 8'hff; req_addr = '0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %h exp 0", req_ready); end
    checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL reset_ack_valid got %b exp 0", ack_valid); end
    checks++; if ({ack_id, ack_q, ack_err} !== '0) begin errors++; $display("FAIL reset_ack_fields got %b exp 0", {ack_id, ack_q, ack_err}); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (q !== '0) begin errors++; $display("FAIL idle_q got %h exp 00", q); end
      checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL idle_ack got %b exp 0", ack_valid); end
    end
  endtask

  task automatic test_single_op();
    logic [1:0] ops [3];
    logic       exp [3];
    ops = '{OP_SET, OP_TOG, OP_RST};
    exp = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, {6'b0, ops[i]}, 12'h003, 1'b0);
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready[%0d] got %b exp 0001", i, req_ready); end
      tick();
      checks++; if (ack_valid !== 1'b1 || ack_id !== 2'd0) begin errors++; $display("FAIL single_ack[%0d] got v=%b id=%0d exp v=1 id=0", i, ack_valid, ack_id); end
      checks++; if (ack_q !== exp[i] || q[3] !== exp[i]) begin errors++; $display("FAIL single_q[%0d] got ack_q=%b q3=%b exp %b", i, ack_q, q[3], exp[i]); end
    end
    drive(4'b0000, 8'h00, 12'h000, 1'b0);
    tick();
    checks++; if (ack_valid !== 1'b0 || ack_q !== 1'b0 || ack_id !== 2'd0) begin errors++; $display("FAIL single_hold got v=%b id=%0d q=%b exp 0/0/0", ack_valid, ack_id, ack_q); end
  endtask

  task automatic test_fairness();
    do_reset();
    drive(4'b1111, 8'hff, 12'h688, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL fair_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
      tick();
      checks++; if (ack_id !== 2'(k % 4) || ack_q !== (k < 4)) begin errors++; $display("FAIL fair_ack[%0d] got id=%0d q=%b exp id=%0d q=%b", k, ack_id, ack_q, k % 4, (k < 4)); end
      if (k == 3) begin
        checks++; if (q !== 6'h0f) begin errors++; $display("FAIL fair_q_half got %h exp 0f", q); end
      end
    end
    checks++; if (q !== 6'h00) begin errors++; $display("FAIL fair_q_full got %h exp 00", q); end
    drive(4'b0000, 8'h00, 12'h000, 1'b0);
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    drive(4'b0001, 8'h00, 12'h000, 1'b0);
    tick();
    drive(4'b0110, 8'h3c, 12'h168, 1'b0);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL cont_ready1 got %b exp 0010", req_ready); end
    tick();
    checks++; if (ack_id !== 2'd1 || ack_q !== 1'b1 || q[5] !== 1'b1) begin errors++; $display("FAIL cont_ack1 got id=%0d q=%b q5=%b exp 1/1/1", ack_id, ack_q, q[5]); end
    drive(4'b0100, 8'h3c, 12'h168, 1'b0);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL cont_ready2 got %b exp 0100", req_ready); end
    tick();
    checks++; if (ack_valid !== 1'b1 || ack_id !== 2'd2 || ack_q !== 1'b0 || q[5] !== 1'b0) begin errors++; $display("FAIL cont_ack2 got v=%b id=%0d q=%b q5=%b exp 1/2/0/0", ack_valid, ack_id, ack_q, q[5]); end
  endtask

  task automatic test_clr();
    drive(4'b0100, 8'h20, 12'h100, 1'b0);
    tick();
    checks++; if (q !== 6'h10) begin errors++; $display("FAIL clr_pre_q got %h exp 10", q); end
    drive(4'b0001, 8'h02, 12'h000, 1'b1);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clr_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (q !== 6'h00 || ack_valid !== 1'b0) begin errors++; $display("FAIL clr_effect got q=%h v=%b exp 00/0", q, ack_valid); end
    drive(4'b0001, 8'h02, 12'h000, 1'b0);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL clr_after_ready got %b exp 0001", req_ready); end
    tick();
    checks++; if (ack_valid !== 1'b1 || ack_id !== 2'd0 || ack_q !== 1'b1 || q !== 6'h01) begin errors++; $display("FAIL clr_after_ack got v=%b id=%0d q=%b bank=%h exp 1/0/1/01", ack_valid, ack_id, ack_q, q); end
  endtask

  task automatic test_error();
    logic [11:0] addrs [3];
    logic        errs  [3];
    logic [5:0]  qexp  [3];
    addrs = '{12'he00, 12'hc00, 12'ha00};
    errs  = '{1'b1, 1'b1, 1'b0};
    qexp  = '{6'h01, 6'h01, 6'h21};
    for (int i = 0; i < 3; i++) begin
      drive(4'b1000, 8'h80, addrs[i], 1'b0);
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL err_ready[%0d] got %b exp 1000", i, req_ready); end
      tick();
      checks++; if (ack_valid !== 1'b1 || ack_id !== 2'd3 || ack_err !== errs[i] || ack_q !== ~errs[i]) begin errors++; $display("FAIL err_ack[%0d] got v=%b id=%0d err=%b q=%b exp 1/3/%b/%b", i, ack_valid, ack_id, ack_err, ack_q, errs[i], ~errs[i]); end
      checks++; if (q !== qexp[i]) begin errors++; $display("FAIL err_q[%0d] got %h exp %h", i, q, qexp[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    drive(4'b1111, 8'hff, 12'h688, 1'b0);
    tick();
    tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (q !== '0 || req_ready !== '0) begin errors++; $display("FAIL mid_reset_q got q=%h rdy=%b exp 00/0", q, req_ready); end
    checks++; if ({ack_valid, ack_id, ack_q, ack_err} !== '0) begin errors++; $display("FAIL mid_reset_ack got %b exp 0", {ack_valid, ack_id, ack_q, ack_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart_ready got %b exp 0001", req_ready); end
    tick();
    checks++; if (ack_id !== 2'd0 || ack_q !== 1'b1 || q !== 6'h01) begin errors++; $display("FAIL mid_restart_ack got id=%0d q=%b bank=%h exp 0/1/01", ack_id, ack_q, q); end
    drive(4'b0000, 8'h00, 12'h000, 1'b0);
    tick();
  endtask

  // Random traffic against a model built from the arbitration and JK rules.
  task automatic test_random();
    logic       pv [NREQ];
    logic [1:0] po [NREQ];
    int         pa [NREQ];
    logic [3:0] granted;
    logic [5:0] qm;
    int         rr, win, idx;
    logic       ev, eq, eerr, c;
    logic [1:0] eid;
    logic [3:0] exp_ready;
    do_reset();
    qm = '0; rr = 0; ev = 0; eq = 0; eerr = 0; eid = '0; granted = '0;
    for (int i = 0; i < NREQ; i++) begin pv[i] = 0; po[i] = '0; pa[i] = 0; end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (pv[i] && !granted[i]) begin
          if ($urandom_range(3) == 0) pv[i] = 1'b0;
        end else begin
          pv[i] = 1'($urandom_range(1));
          po[i] = 2'($urandom_range(3));
          pa[i] = $urandom_range(7);
        end
        req_valid[i]      = pv[i];
        req_op[2*i +: 2]  = po[i];
        req_addr[3*i +: 3] = 3'(pa[i]);
      end
      c = ($urandom_range(15) == 0);
      clr = c;
      #1;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (pv[idx] && win < 0) win = idx;
      end
      exp_ready = (!c && win >= 0) ? 4'(1 << win) : 4'b0000;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got %b exp %b", n, req_ready, exp_ready); end
      granted = exp_ready;
      if (c) begin
        qm = '0; ev = 0;
      end else if (win >= 0) begin
        ev = 1; eid = 2'(win);
        if (pa[win] < NBITS) begin
          case (po[win])
            OP_RST:  qm[pa[win]] = 1'b0;
            OP_SET:  qm[pa[win]] = 1'b1;
            OP_TOG:  qm[pa[win]] = ~qm[pa[win]];
            default: ;
          endcase
          eq = qm[pa[win]]; eerr = 0;
        end else begin
          eq = 0; eerr = 1;
        end
        rr = (win + 1) % NREQ;
      end else begin
        ev = 0;
      end
      tick();
      checks++; if (q !== qm) begin errors++; $display("FAIL rand_q[%0d] got %h exp %h", n, q, qm); end
      checks++; if ({ack_valid, ack_id, ack_q, ack_err} !== {ev, eid, eq, eerr}) begin errors++; $display("FAIL rand_ack[%0d] got v/id/q/err=%b/%0d/%b/%b exp %b/%0d/%b/%b", n, ack_valid, ack_id, ack_q, ack_err, ev, eid, eq, eerr); end
    end
    clr = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_contention();
    test_clr();
    test_error();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin arbiter and command sequencer sharing one bank of JK flip-flop cells among several requesters. Each requester issues hold/reset/set/toggle commands to one addressed bit over a valid/ready handshake. The block grants at most one command per cycle, drives J/K for the target cell only, and returns a registered acknowledgement carrying the updated bit value. It sits between control agents and the shared JK state bank.

## Interface
- NREQ, 4, number of requesters (≥2)
- NBITS, 8, number of JK cells in the bank (≥1)
- AW, $clog2(NBITS) (min 1), per-requester address width
- IDW, $clog2(NREQ) (min 1), requester-id width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of the whole bank; has priority over commands
- req_valid  in  NREQ  command valid, one bit per requester
- req_op  in  2*NREQ  per-requester op {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
- req_addr  in  AW*NREQ  per-requester target bit index
- req_ready  out  NREQ  one-hot grant; a command transfers when valid&ready
- q  out  NBITS  bank state
- ack_valid  out  1  one-cycle pulse, one per accepted command
- ack_id  out  IDW  requester index of the acked command
- ack_q  out  1  value of the addressed bit after the update
- ack_err  out  1  addressed bit ≥ NBITS; no bank change

## Operation
- Arbitration is round-robin from rr_ptr. The winner is the first valid requester at or after rr_ptr (modulo NREQ).
- req_ready is combinational and at most one-hot: set for the winner only, all zero when no valid or when clr=1.
- After a transfer, rr_ptr ← winner+1 (wraps NREQ-1 → 0). With no transfer, rr_ptr is unchanged.
- Decode for an accepted command: the addressed cell gets J=op[1], K=op[0]; every other cell gets J=K=0 (hold).
- Cell behaviour: 00 hold, 01 Q←0, 10 Q←1, 11 Q←~Q.
- An out-of-range address (only possible when NBITS is not a power of 2) is still accepted and acked with ack_err=1 and ack_q=0. q is unchanged.
- clr=1: q←0 at the next edge, no grant, rr_ptr held, ack_valid←0.
- A requester holding req_valid with no ready keeps its op/addr stable. Dropping valid before transfer is permitted.

## Timing
- Throughput: one command per cycle.
- Latency: a transfer at edge N updates q at edge N and pulses ack_valid/ack_id/ack_q/ack_err in the cycle after edge N (registered, 1 cycle).
- ack_q equals q[addr] as visible in that same ack cycle.
- ack_valid=0 in any cycle following an edge with no transfer. ack_id/ack_q/ack_err hold their last values when ack_valid=0.
- Back-to-back toggles to the same bit from different requesters on consecutive cycles each see the prior result: no lost update.
- Reset (rst_n=0, any time, asynchronous): q=0, rr_ptr=0, req_ready=0, ack_valid=0, ack_id=0, ack_q=0, ack_err=0. A command presented during reset is not accepted and not acked.
- First rising edge after rst_n deassertion may accept a command.

## Structure
- Package jk_pkg holds the op encoding localparams OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TOG=2'b11 and the helper for the minimum-1 clog2.
- Sub-module jk_cell: a single JK flop with clk and asynchronous active-low rst_n, instantiated NBITS times via generate.
- Round-robin pick, J/K decode and ack registers live in the top level.

## Test plan
- Reset/idle: hold rst_n=0 with all req_valid=1 → q=0, req_ready=0, ack_valid=0. Release, no valids → q stays 0, no ack.
- Single op sequence: req0 set addr3, then toggle addr3, then reset addr3 on consecutive cycles → q[3] goes 1, 0, 0; three acks with ack_id=0 and ack_q 1, 0, 0.
- Fairness: all 4 requesters valid continuously, each toggling its own bit (addr=id) → grants rotate 0,1,2,3,0. Each q bit toggles once per 4 cycles.
- Contention on one bit: req1 and req2 both toggle addr5 with rr_ptr=1 → req1 acked first (ack_q=1), req2 next cycle (ack_q=0). q[5]=0.
- clr priority: req0 valid with set addr0 while clr=1 → req_ready=0, q=0, no ack. Next cycle with clr=0 → accepted, ack_q=1.
- Reset mid-stream / error: NBITS=6, req3 addr7 → ack_err=1, q unchanged. Assert rst_n=0 during a stream → all outputs 0 immediately and rr_ptr restarts at 0.
